// File: rtl/gpio_uart_pkg.sv
// Shared types and constants for the GPIO-change UART reporter.
// Holds the FSM state encoding and the byte-formatting helper.
package gpio_uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_BASE = 8'h30;

  // ASCII mode adds the '0' offset; otherwise the value is zero-extended.
  function automatic logic [7:0] form_byte(input logic [6:0] v, input logic ascii);
    return ascii ? ASCII_BASE + {1'b0, v} : {1'b0, v};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with an occupancy count. The count is kept separately from
// the pointers so that full and empty are unambiguous.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push on full is still accepted when a pop frees the head slot.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !rd_en) level_d = level_q + (AW+1)'(1);
    else if (rd_en && !wr_en) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/gpio_uart_reporter.sv
// Queues one byte per change of the monitored GPIO value and hands the bytes
// to uart_tx with a start/done handshake, guarded by a WAIT watchdog.
module gpio_uart_reporter
  import gpio_uart_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ASCII   = 1,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       en,
  input  logic [WIDTH-1:0]           value_in,
  input  logic                       err_clr,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       busy,
  output logic                       overflow,
  output logic                       tx_timeout
);

  localparam int unsigned WdW = $clog2(TIMEOUT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic             ovf_q, ovf_d, tmo_q, tmo_d;
  logic             tmo_set, ovf_set;

  logic             push, pop;
  logic [7:0]       wbyte, fifo_rdata;
  logic             fifo_full, fifo_empty;

  assign push    = en && (value_in != prev_q);
  assign pop     = (state_q == StIdle) && !fifo_empty;
  assign wbyte   = form_byte(7'(value_in), ASCII != 0);
  assign ovf_set = push && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i  (HCLK),
    .rst_ni (HRESETn),
    .push   (push),
    .pop    (pop),
    .wdata  (wbyte),
    .rdata  (fifo_rdata),
    .level  (level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    prev_d     = value_in;
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    wd_d       = wd_q;
    tmo_set    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          tx_data_d  = fifo_rdata;
          tx_start_d = 1'b1;
          state_d    = StStart;
        end
      end
      StStart: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        if (tx_done) begin
          state_d = StIdle;
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          tmo_set = 1'b1;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // A set event in the same cycle as err_clr wins.
    ovf_d = ovf_set ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    tmo_d = tmo_set ? 1'b1 : (err_clr ? 1'b0 : tmo_q);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= StIdle;
      prev_q     <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      wd_q       <= '0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      wd_q       <= wd_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign busy       = (state_q != StIdle) || !fifo_empty;
  assign overflow   = ovf_q;
  assign tx_timeout = tmo_q;

endmodule

// File: tb/tb_gpio_uart_reporter.sv
// Bench for gpio_uart_reporter: directed vector table, hand-written corner
// sequences and random traffic checked against a queue-based reference model.
module tb_gpio_uart_reporter;

  localparam int WIDTH   = 3;
  localparam int DEPTH   = 4;
  localparam int ASCII   = 1;
  localparam int TIMEOUT = 20;

  logic                   HCLK = 1'b0;
  logic                   HRESETn = 1'b0;
  logic                   en = 1'b0;
  logic                   err_clr = 1'b0;
  logic                   tx_done = 1'b0;
  logic [WIDTH-1:0]       value_in = '0;
  logic                   tx_start;
  logic [7:0]             tx_data;
  logic [$clog2(DEPTH):0] level;
  logic                   busy, overflow, tx_timeout;

  int checks = 0;
  int errors = 0;
  int sent_log[$];

  always #5 HCLK = ~HCLK;

  gpio_uart_reporter #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .ASCII   (ASCII),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .en         (en),
    .value_in   (value_in),
    .err_clr    (err_clr),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .level      (level),
    .busy       (busy),
    .overflow   (overflow),
    .tx_timeout (tx_timeout)
  );

  // Reference model: a byte queue plus the frame in flight.
  int m_q[$];
  int m_prev, m_data, m_waited;
  bit m_starting, m_sending, m_ovf, m_tmo;

  function automatic int to_byte(input int v);
    return (ASCII != 0) ? (48 + v) % 256 : v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_prev = 0; m_data = 0; m_waited = 0;
    m_starting = 0; m_sending = 0; m_ovf = 0; m_tmo = 0;
  endtask

  task automatic model_edge();
    bit changed, popped, ovf_set, tmo_set;
    changed = en && (int'(value_in) != m_prev);
    popped  = !m_starting && !m_sending && (m_q.size() != 0);
    ovf_set = 0;
    tmo_set = 0;
    if (m_sending) begin
      if (tx_done) m_sending = 0;
      else begin
        m_waited++;
        if (m_waited == TIMEOUT) begin
          tmo_set = 1;
          m_sending = 0;
        end
      end
    end else if (m_starting) begin
      m_starting = 0;
      m_sending = 1;
      m_waited = 0;
    end
    if (popped) begin
      m_data = m_q.pop_front();
      m_starting = 1;
    end
    if (changed) begin
      if (m_q.size() < DEPTH) m_q.push_back(to_byte(int'(value_in)));
      else ovf_set = 1;
    end
    m_ovf  = ovf_set ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
    m_tmo  = tmo_set ? 1'b1 : (err_clr ? 1'b0 : m_tmo);
    m_prev = int'(value_in);
  endtask

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) model_reset();
    else model_edge();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".tx_start"}, 32'(tx_start), 32'(m_starting));
    chk({tag, ".tx_data"}, 32'(tx_data), m_data);
    chk({tag, ".level"}, 32'(level), m_q.size());
    chk({tag, ".busy"}, 32'(busy), 32'(m_starting || m_sending || m_q.size() != 0));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".tx_timeout"}, 32'(tx_timeout), 32'(m_tmo));
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
    if (tx_start === 1'b1) sent_log.push_back(int'(tx_data));
  endtask

  task automatic drain(input string tag);
    tx_done = 1'b1;
    for (int i = 0; i < 50 && busy !== 1'b0; i++) begin
      tick();
      check_model(tag);
    end
    tx_done = 1'b0;
    chk({tag, ".drain_bound"}, 32'(busy), 0);
  endtask

  typedef struct {
    bit en;
    int val;
    bit done;
    int e_start;
    int e_data;
    int e_level;
    int e_busy;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int n;
    int exp_seq[6];

    vecs[0]  = '{1, 0, 0, 0, 8'h00, 0, 0};
    vecs[1]  = '{1, 5, 0, 0, 8'h00, 1, 1};
    vecs[2]  = '{1, 5, 0, 1, 8'h35, 0, 1};
    vecs[3]  = '{1, 5, 0, 0, 8'h35, 0, 1};
    vecs[4]  = '{1, 5, 1, 0, 8'h35, 0, 0};
    vecs[5]  = '{1, 6, 0, 0, 8'h35, 1, 1};
    vecs[6]  = '{1, 6, 1, 1, 8'h36, 0, 1};
    vecs[7]  = '{1, 7, 1, 0, 8'h36, 1, 1};
    vecs[8]  = '{1, 7, 1, 0, 8'h36, 1, 1};
    vecs[9]  = '{1, 7, 0, 1, 8'h37, 0, 1};
    vecs[10] = '{1, 7, 0, 0, 8'h37, 0, 1};
    vecs[11] = '{1, 7, 1, 0, 8'h37, 0, 0};
    vecs[12] = '{0, 2, 0, 0, 8'h37, 0, 0};
    vecs[13] = '{1, 2, 0, 0, 8'h37, 0, 0};
    vecs[14] = '{1, 0, 0, 0, 8'h37, 1, 1};
    vecs[15] = '{1, 0, 0, 1, 8'h30, 0, 1};

    // Reset state.
    tick();
    tick();
    chk("rst.tx_start", 32'(tx_start), 0);
    chk("rst.tx_data", 32'(tx_data), 0);
    chk("rst.level", 32'(level), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.overflow", 32'(overflow), 0);
    chk("rst.tx_timeout", 32'(tx_timeout), 0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      en = vecs[i].en;
      value_in = WIDTH'(vecs[i].val);
      tx_done = vecs[i].done;
      tick();
      chk($sformatf("vec%0d.tx_start", i), 32'(tx_start), vecs[i].e_start);
      chk($sformatf("vec%0d.tx_data", i), 32'(tx_data), vecs[i].e_data);
      chk($sformatf("vec%0d.level", i), 32'(level), vecs[i].e_level);
      chk($sformatf("vec%0d.busy", i), 32'(busy), vecs[i].e_busy);
      chk($sformatf("vec%0d.overflow", i), 32'(overflow), 0);
    end
    tx_done = 1'b0;
    drain("vec_drain");

    // Overflow while a frame is stalled in WAIT, then full FIFO with pop+push.
    sent_log.delete();
    en = 1'b1;
    value_in = 3'd7;
    tick(); check_model("ovf");
    tick(); check_model("ovf");
    tick(); check_model("ovf");
    for (int v = 1; v <= 5; v++) begin
      value_in = WIDTH'(v);
      tick();
      check_model("ovf");
    end
    chk("ovf.level_full", 32'(level), 4);
    chk("ovf.flag_set", 32'(overflow), 1);
    err_clr = 1'b1;
    tick(); check_model("ovf_clr");
    err_clr = 1'b0;
    chk("ovf.flag_cleared", 32'(overflow), 0);
    tx_done = 1'b1;
    tick(); check_model("full_done");
    tx_done = 1'b0;
    value_in = 3'd6;
    tick(); check_model("full_pp");
    chk("full_pp.level", 32'(level), 4);
    chk("full_pp.overflow", 32'(overflow), 0);
    chk("full_pp.tx_start", 32'(tx_start), 1);
    drain("ovf_drain");
    exp_seq = '{8'h37, 8'h31, 8'h32, 8'h33, 8'h34, 8'h36};
    chk("ovf.sent_count", sent_log.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("ovf.sent%0d", i), (i < sent_log.size()) ? sent_log[i] : -1, exp_seq[i]);

    // Watchdog abort; err_clr held during the abort cycle must lose to the set.
    value_in = 3'd1;
    tick(); check_model("tmo");
    value_in = 3'd2;
    tick(); check_model("tmo");
    chk("tmo.start", 32'(tx_start), 1);
    err_clr = 1'b1;
    n = 0;
    while (tx_timeout !== 1'b1 && n < 100) begin
      tick();
      n++;
      check_model("tmo_wait");
    end
    err_clr = 1'b0;
    chk("tmo.cycles", n, TIMEOUT + 1);
    tick(); check_model("tmo_next");
    chk("tmo.next_start", 32'(tx_start), 1);
    chk("tmo.next_data", 32'(tx_data), 8'h32);
    drain("tmo_drain");
    err_clr = 1'b1;
    tick(); check_model("tmo_clr");
    err_clr = 1'b0;
    chk("tmo.cleared", 32'(tx_timeout), 0);

    // en low blocks events; raising en on a stable value is not an event.
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      value_in = WIDTH'(i);
      tick();
      check_model("en_off");
    end
    en = 1'b1;
    tick(); check_model("en_on");
    chk("en_on.level", 32'(level), 0);
    chk("en_on.busy", 32'(busy), 0);

    // Reset during WAIT with two bytes queued.
    value_in = 3'd3; tick(); check_model("rst_mid");
    value_in = 3'd4; tick(); check_model("rst_mid");
    value_in = 3'd5; tick(); check_model("rst_mid");
    tick(); check_model("rst_mid");
    chk("rst_mid.level_before", 32'(level), 2);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("rst_mid.level", 32'(level), 0);
    chk("rst_mid.tx_start", 32'(tx_start), 0);
    chk("rst_mid.busy", 32'(busy), 0);
    value_in = '0;
    tick();
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_model("rst_after");
    end
    chk("rst_after.sent", 32'(tx_start), 0);

    // Random traffic with alternating stall and normal phases.
    for (int i = 0; i < 800; i++) begin
      bit stall;
      stall = ((i / 64) % 2) == 1;
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) == 0) value_in = WIDTH'($urandom);
      tx_done = stall ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
      err_clr = ($urandom_range(0, 19) == 0);
      tick();
      check_model("rand");
    end
    err_clr = 1'b0;
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
